gbar_collector: RTL and testbench



---
 rtl/gbar_collector.sv | 150 +++++++++++++++
 tb/tb_gbar_collector.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gbar_collector.sv
// Cluster global-barrier collector: round-robin accepts per-core barrier arrivals and
// broadcasts a one-cycle release when enough cores have arrived. Define GBAR_STATS_EN for counters.
module gbar_collector #(
    parameter int NUM_CORES    = 4,
    parameter int NUM_BARRIERS = 4,
    parameter int NB_WIDTH     = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1,
    parameter int NC_WIDTH     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CORES-1:0]          req_valid,
    input  logic [NUM_CORES*NB_WIDTH-1:0] req_id,
    input  logic [NUM_CORES*NC_WIDTH-1:0] req_size_m1,
    output logic [NUM_CORES-1:0]          req_ready,
    output logic                          rsp_valid,
    output logic [NB_WIDTH-1:0]           rsp_id,
    output logic                          busy,
    output logic                          dup_err
`ifdef GBAR_STATS_EN
    ,
    output logic [31:0]                   stat_releases,
    output logic [31:0]                   stat_wait_cycles
`endif
);

    localparam int CNT_W = NC_WIDTH + 1;

    logic [NUM_BARRIERS-1:0][NUM_CORES-1:0] arrive_mask_q, arrive_mask_d;
    logic [NC_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [NB_WIDTH-1:0] rsp_id_q, rsp_id_d;
    logic                dup_err_q, dup_err_d;

    logic                 grant_found;
    logic [NC_WIDTH-1:0]  grant_idx;
    logic [NB_WIDTH-1:0]  grant_id;
    logic [NC_WIDTH-1:0]  grant_size;
    logic                 id_bad;
    logic [NUM_CORES-1:0] merged;
    logic [CNT_W-1:0]     arrive_cnt;

    function automatic int wrap_core(input int a);
        return a % NUM_CORES;
    endfunction

    // Search upward from rr_ptr; nothing is granted while reset is held.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_id    = '0;
        grant_size  = '0;
        req_ready   = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (!grant_found && !reset && req_valid[wrap_core(int'(rr_ptr_q) + k)]) begin
                grant_found = 1'b1;
                grant_idx   = NC_WIDTH'(wrap_core(int'(rr_ptr_q) + k));
                grant_id    = req_id[wrap_core(int'(rr_ptr_q) + k)*NB_WIDTH +: NB_WIDTH];
                grant_size  = req_size_m1[wrap_core(int'(rr_ptr_q) + k)*NC_WIDTH +: NC_WIDTH];
            end
        end
        if (grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    generate
        if ((2 ** NB_WIDTH) > NUM_BARRIERS) begin : g_id_chk
            assign id_bad = (int'(grant_id) >= NUM_BARRIERS);
        end else begin : g_no_id_chk
            assign id_bad = 1'b0;
        end
    endgenerate

    always_comb begin
        merged     = '0;
        arrive_cnt = '0;
        if (!id_bad) begin
            merged = arrive_mask_q[grant_id] | (NUM_CORES'(1) << grant_idx);
        end
        for (int i = 0; i < NUM_CORES; i++) begin
            arrive_cnt = arrive_cnt + CNT_W'(merged[i]);
        end
    end

    always_comb begin
        arrive_mask_d = arrive_mask_q;
        rr_ptr_d      = rr_ptr_q;
        rsp_valid_d   = 1'b0;
        rsp_id_d      = rsp_id_q;
        dup_err_d     = dup_err_q;
        if (grant_found) begin
            rr_ptr_d = NC_WIDTH'(wrap_core(int'(grant_idx) + 1));
            if (id_bad || arrive_mask_q[grant_id][grant_idx]) begin
                dup_err_d = 1'b1;
            end else if (arrive_cnt >= (CNT_W'(grant_size) + CNT_W'(1))) begin
                arrive_mask_d[grant_id] = '0;
                rsp_valid_d             = 1'b1;
                rsp_id_d                = grant_id;
            end else begin
                arrive_mask_d[grant_id] = merged;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            arrive_mask_q <= '0;
            rr_ptr_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= '0;
            dup_err_q     <= 1'b0;
        end else begin
            arrive_mask_q <= arrive_mask_d;
            rr_ptr_q      <= rr_ptr_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_id_q      <= rsp_id_d;
            dup_err_q     <= dup_err_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign dup_err   = dup_err_q;
    // Masked by reset so busy reads 0 in the reset cycle before the mask has cleared.
    assign busy      = (|arrive_mask_q) & ~reset;

`ifdef GBAR_STATS_EN
    logic [31:0] stat_releases_q, stat_releases_d;
    logic [31:0] stat_wait_cycles_q, stat_wait_cycles_d;

    always_comb begin
        stat_releases_d    = stat_releases_q + 32'(rsp_valid_q);
        stat_wait_cycles_d = stat_wait_cycles_q + 32'(|arrive_mask_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_releases_q    <= '0;
            stat_wait_cycles_q <= '0;
        end else begin
            stat_releases_q    <= stat_releases_d;
            stat_wait_cycles_q <= stat_wait_cycles_d;
        end
    end

    assign stat_releases    = stat_releases_q;
    assign stat_wait_cycles = stat_wait_cycles_q;
`endif

endmodule

// File: tb/tb_gbar_collector.sv
// Bench for gbar_collector: directed scenarios plus a randomized run against a set-based model.
module tb_gbar_collector;

    localparam int NC  = 4;
    localparam int NB  = 4;
    localparam int NBW = 2;
    localparam int NCW = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [NC-1:0]     req_valid;
    logic [NBW-1:0]    id_c [NC];
    logic [NCW-1:0]    sz_c [NC];
    logic [NC*NBW-1:0] req_id;
    logic [NC*NCW-1:0] req_size_m1;
    logic [NC-1:0]     req_ready;
    logic              rsp_valid;
    logic [NBW-1:0]    rsp_id;
    logic              busy;
    logic              dup_err;
`ifdef GBAR_STATS_EN
    logic [31:0]       stat_releases;
    logic [31:0]       stat_wait_cycles;
    int                busy_cnt = 0;
    int                rel_cnt  = 0;
`endif

    assign req_id      = {id_c[3], id_c[2], id_c[1], id_c[0]};
    assign req_size_m1 = {sz_c[3], sz_c[2], sz_c[1], sz_c[0]};

    gbar_collector #(.NUM_CORES(NC), .NUM_BARRIERS(NB)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_id(req_id),
        .req_size_m1(req_size_m1), .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_id(rsp_id), .busy(busy), .dup_err(dup_err)
`ifdef GBAR_STATS_EN
        , .stat_releases(stat_releases), .stat_wait_cycles(stat_wait_cycles)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic tick();
`ifdef GBAR_STATS_EN
        if (busy) busy_cnt++;
        if (rsp_valid) rel_cnt++;
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int c, input int b, input int s);
        req_valid    = '0;
        req_valid[c] = 1'b1;
        id_c[c]      = 2'(b);
        sz_c[c]      = 2'(s);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        req_valid = '1;
        tick();
        n_checks++;
        if (req_ready !== 4'b0 || busy !== 1'b0 || rsp_valid !== 1'b0 || dup_err !== 1'b0)
            $display("FAIL reset_state: ready=%b busy=%b rsp=%b dup=%b want 0000/0/0/0",
                     req_ready, busy, rsp_valid, dup_err);
        else n_pass++;
        req_valid = '0;
        reset     = 1'b0;
        tick();
    endtask

    task automatic test_sequential();
        do_reset();
        for (int c = 0; c < NC; c++) begin
            set_req(c, 1, 3);
            #1;
            n_checks++;
            if (req_ready !== (4'b1 << c))
                $display("FAIL seq_grant%0d: ready=%b want %b", c, req_ready, 4'b1 << c);
            else n_pass++;
            tick();
            if (c < NC - 1) begin
                n_checks++;
                if (busy !== 1'b1 || rsp_valid !== 1'b0)
                    $display("FAIL seq_wait%0d: busy=%b rsp=%b want 1/0", c, busy, rsp_valid);
                else n_pass++;
            end
        end
        req_valid = '0;
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1)
            $display("FAIL seq_release: rsp=%b id=%0d want 1/1", rsp_valid, rsp_id);
        else n_pass++;
        tick();
        n_checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL seq_after: rsp=%b busy=%b want 0/0", rsp_valid, busy);
        else n_pass++;
    endtask

    task automatic test_contention();
        do_reset();
        req_valid = '1;
        for (int c = 0; c < NC; c++) begin
            id_c[c] = 2'd0;
            sz_c[c] = 2'd3;
        end
        for (int c = 0; c < NC; c++) begin
            #1;
            n_checks++;
            if (req_ready !== (4'b1 << c))
                $display("FAIL rr_grant%0d: ready=%b want %b", c, req_ready, 4'b1 << c);
            else n_pass++;
            tick();
            req_valid[c] = 1'b0;
        end
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0)
            $display("FAIL rr_release: rsp=%b id=%0d want 1/0", rsp_valid, rsp_id);
        else n_pass++;
        req_valid = '1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001)
            $display("FAIL rr_ptr_wrap: ready=%b want 0001", req_ready);
        else n_pass++;
        req_valid = '0;
        tick();
    endtask

    task automatic test_size_one();
        set_req(2, 3, 0);
        #1;
        n_checks++;
        if (req_ready !== 4'b0100) $display("FAIL single_grant: ready=%b want 0100", req_ready);
        else n_pass++;
        tick();
        req_valid = '0;
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || busy !== 1'b0)
            $display("FAIL single_release: rsp=%b id=%0d busy=%b want 1/3/0", rsp_valid, rsp_id, busy);
        else n_pass++;
        tick();
        n_checks++;
        if (rsp_valid !== 1'b0) $display("FAIL single_pulse: rsp=%b want 0", rsp_valid);
        else n_pass++;
    endtask

    task automatic test_duplicate();
        do_reset();
        set_req(1, 2, 1);
        tick();
        set_req(1, 2, 1);
        tick();
        req_valid = '0;
        n_checks++;
        if (dup_err !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b1)
            $display("FAIL dup_flag: dup=%b rsp=%b busy=%b want 1/0/1", dup_err, rsp_valid, busy);
        else n_pass++;
        tick();
        set_req(0, 2, 1);
        tick();
        req_valid = '0;
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || dup_err !== 1'b1 || busy !== 1'b0)
            $display("FAIL dup_release: rsp=%b id=%0d dup=%b busy=%b want 1/2/1/0",
                     rsp_valid, rsp_id, dup_err, busy);
        else n_pass++;
        tick();
    endtask

    task automatic test_interleave_and_reset();
        do_reset();
        set_req(0, 0, 1); tick();
        set_req(1, 1, 1); tick();
        set_req(1, 0, 1); tick();
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || busy !== 1'b1)
            $display("FAIL inter_id0: rsp=%b id=%0d busy=%b want 1/0/1", rsp_valid, rsp_id, busy);
        else n_pass++;
        set_req(0, 1, 1); tick();
        req_valid = '0;
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || busy !== 1'b0 || dup_err !== 1'b0)
            $display("FAIL inter_id1: rsp=%b id=%0d busy=%b dup=%b want 1/1/0/0",
                     rsp_valid, rsp_id, busy, dup_err);
        else n_pass++;
        set_req(0, 3, 1); tick();
        req_valid = '0;
        reset     = 1'b1;
        #1;
        n_checks++;
        if (busy !== 1'b0 || req_ready !== 4'b0)
            $display("FAIL midreset_busy: busy=%b ready=%b want 0/0000", busy, req_ready);
        else n_pass++;
        tick();
        reset = 1'b0;
        n_checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL midreset_after: rsp=%b busy=%b want 0/0", rsp_valid, busy);
        else n_pass++;
        set_req(1, 3, 1); tick();
        req_valid = '0;
        n_checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b1)
            $display("FAIL midreset_fresh1: rsp=%b busy=%b want 0/1", rsp_valid, busy);
        else n_pass++;
        set_req(0, 3, 1); tick();
        req_valid = '0;
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd3)
            $display("FAIL midreset_fresh2: rsp=%b id=%0d want 1/3", rsp_valid, rsp_id);
        else n_pass++;
        tick();
    endtask

    // Model: per-barrier set of arrived cores, pointer to the first core to consider next.
    task automatic test_random();
        bit arrived [NB][NC];
        int m_rr, m_rid, w, b, cnt;
        bit m_rv, m_dup, exp_busy;
        logic [NC-1:0] exp_ready;
        do_reset();
        foreach (arrived[i, j]) arrived[i][j] = 1'b0;
        m_rr = 0; m_rv = 1'b0; m_rid = 0; m_dup = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            reset     = ($urandom_range(99) < 2);
            req_valid = 4'($urandom);
            for (int c = 0; c < NC; c++) begin
                id_c[c] = 2'($urandom);
                sz_c[c] = 2'($urandom_range(2));
            end
            #1;
            w = -1;
            if (!reset)
                for (int k = 0; k < NC; k++)
                    if (w < 0 && req_valid[(m_rr + k) % NC]) w = (m_rr + k) % NC;
            exp_ready = (w >= 0) ? (4'b1 << w) : 4'b0;
            exp_busy = 1'b0;
            if (!reset) foreach (arrived[i, j]) if (arrived[i][j]) exp_busy = 1'b1;
            n_checks++;
            if (req_ready !== exp_ready || rsp_valid !== m_rv || busy !== exp_busy || dup_err !== m_dup
                || (m_rv && rsp_id !== 2'(m_rid)))
                $display("FAIL rand_cyc%0d: ready=%b rsp=%b id=%0d busy=%b dup=%b want %b/%b/%0d/%b/%b",
                         cyc, req_ready, rsp_valid, rsp_id, busy, dup_err,
                         exp_ready, m_rv, m_rid, exp_busy, m_dup);
            else n_pass++;
            if (reset) begin
                foreach (arrived[i, j]) arrived[i][j] = 1'b0;
                m_rr = 0; m_rv = 1'b0; m_rid = 0; m_dup = 1'b0;
            end else begin
                m_rv = 1'b0;
                if (w >= 0) begin
                    b    = int'(id_c[w]);
                    m_rr = (w + 1) % NC;
                    if (arrived[b][w]) m_dup = 1'b1;
                    else begin
                        arrived[b][w] = 1'b1;
                        cnt = 0;
                        for (int j = 0; j < NC; j++) cnt += int'(arrived[b][j]);
                        if (cnt >= int'(sz_c[w]) + 1) begin
                            for (int j = 0; j < NC; j++) arrived[b][j] = 1'b0;
                            m_rv  = 1'b1;
                            m_rid = b;
                        end
                    end
                end
            end
            tick();
        end
        reset     = 1'b0;
        req_valid = '0;
        tick();
    endtask

`ifdef GBAR_STATS_EN
    task automatic test_stats();
        do_reset();
        busy_cnt = 0;
        rel_cnt  = 0;
        for (int r = 0; r < 3; r++) begin
            set_req(0, r, 1); tick();
            req_valid = '0; tick();
            set_req(1, r, 1); tick();
        end
        req_valid = '0;
        tick();
        tick();
        n_checks++;
        if (stat_releases !== 32'd3 || stat_wait_cycles !== 32'(busy_cnt) || rel_cnt != 3)
            $display("FAIL stats: releases=%0d wait=%0d want 3/%0d (pulses seen %0d)",
                     stat_releases, stat_wait_cycles, busy_cnt, rel_cnt);
        else n_pass++;
    endtask
`endif

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        for (int c = 0; c < NC; c++) begin
            id_c[c] = '0;
            sz_c[c] = '0;
        end
        test_reset();
        test_sequential();
        test_contention();
        test_size_one();
        test_duplicate();
        test_interleave_and_reset();
        test_random();
`ifdef GBAR_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
